// File: rtl/immediate_encode.sv
// Two-stage pipelined RV32 immediate encoder: scatters a 32-bit immediate into
// instruction[31:7] for the selected format, range-checks it and tracks errors.
module immediate_encode #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [31:0]          IMM,
  input  logic [2:0]           IMM_SEL,
  input  logic [24:0]          BASE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [24:0]          OUT,
  output logic                 OUT_ERR,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  input  logic                 CLR_ERR
);

  localparam logic [2:0] SEL_U  = 3'b000;
  localparam logic [2:0] SEL_J  = 3'b001;
  localparam logic [2:0] SEL_S  = 3'b010;
  localparam logic [2:0] SEL_B  = 3'b011;
  localparam logic [2:0] SEL_I  = 3'b100;
  localparam logic [2:0] SEL_SH = 3'b101;
  localparam logic [2:0] SEL_IU = 3'b110;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  function automatic logic [24:0] encode_imm(input logic [31:0] imm,
                                             input logic [2:0]  sel,
                                             input logic [24:0] base);
    logic [24:0] o;
    o = base;
    case (sel)
      SEL_U:  o[24:5] = imm[31:12];
      SEL_J: begin
        o[24]    = imm[20];
        o[23:14] = imm[10:1];
        o[13]    = imm[11];
        o[12:5]  = imm[19:12];
      end
      SEL_S: begin
        o[24:18] = imm[11:5];
        o[4:0]   = imm[4:0];
      end
      SEL_B: begin
        o[24]    = imm[12];
        o[23:18] = imm[10:5];
        o[4:1]   = imm[4:1];
        o[0]     = imm[11];
      end
      SEL_I, SEL_IU: o[24:13] = imm[11:0];
      SEL_SH: o[17:13] = imm[4:0];
      default: o = base;
    endcase
    return o;
  endfunction

  // Low bits are still encoded when this flags; it only reports loss of information.
  function automatic logic range_err(input logic [31:0] imm, input logic [2:0] sel);
    logic e;
    case (sel)
      SEL_U:         e = (imm[11:0] != 12'd0);
      SEL_J:         e = imm[0] | (imm[31:20] != {12{imm[20]}});
      SEL_B:         e = imm[0] | (imm[31:12] != {20{imm[12]}});
      SEL_S, SEL_I:  e = (imm[31:11] != {21{imm[11]}});
      SEL_IU:        e = (imm[31:12] != 20'd0);
      SEL_SH:        e = (imm[31:5] != 27'd0);
      default:       e = 1'b1;
    endcase
    return e;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_imm_q, s1_imm_d;
  logic [2:0]           s1_sel_q, s1_sel_d;
  logic [24:0]          s1_base_q, s1_base_d;
  logic                 out_valid_q, out_valid_d;
  logic [24:0]          out_q, out_d;
  logic                 out_err_q, out_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic s2_adv;
  logic in_fire;
  logic out_fire;

  assign s2_adv   = !out_valid_q || OUT_READY;
  assign IN_READY = !s1_valid_q || s2_adv;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = out_valid_q && OUT_READY;

  assign OUT_VALID  = out_valid_q;
  assign OUT        = out_q;
  assign OUT_ERR    = out_err_q;
  assign ERR_STICKY = err_sticky_q;
  assign ERR_CNT    = err_cnt_q;

  // Next-state for both pipeline stages and the error accounting.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_imm_d     = s1_imm_q;
    s1_sel_d     = s1_sel_q;
    s1_base_d    = s1_base_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = IMM;
      s1_sel_d   = IMM_SEL;
      s1_base_d  = BASE;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d     = encode_imm(s1_imm_q, s1_sel_q, s1_base_q);
        out_err_d = range_err(s1_imm_q, s1_sel_q);
      end else begin
        out_d     = out_q;
        out_err_d = out_err_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    // Clear has priority over a coincident errored handshake.
    if (CLR_ERR) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (out_fire && out_err_q) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // State registers; reset drops any in-flight items.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_q   <= 1'b0;
      s1_imm_q     <= 32'd0;
      s1_sel_q     <= 3'd0;
      s1_base_q    <= 25'd0;
      out_valid_q  <= 1'b0;
      out_q        <= 25'd0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_imm_q     <= s1_imm_d;
      s1_sel_q     <= s1_sel_d;
      s1_base_q    <= s1_base_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_immediate_encode.sv
// Directed + random bench for immediate_encode with a queue-based scoreboard;
// a second instance with a 2-bit counter covers saturation.
module tb_immediate_encode;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, OUT_READY, CLR_ERR;
  logic [31:0] IMM;
  logic [2:0]  IMM_SEL;
  logic [24:0] BASE;

  logic        in_ready, out_valid, out_err, err_sticky;
  logic [24:0] out_w;
  logic [15:0] err_cnt;
  logic        s_in_ready, s_out_valid, s_out_err, s_sticky;
  logic [24:0] s_out;
  logic [1:0]  s_cnt;

  immediate_encode #(.ERR_CNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready),
    .IMM(IMM), .IMM_SEL(IMM_SEL), .BASE(BASE), .OUT_VALID(out_valid),
    .OUT_READY(OUT_READY), .OUT(out_w), .OUT_ERR(out_err),
    .ERR_STICKY(err_sticky), .ERR_CNT(err_cnt), .CLR_ERR(CLR_ERR)
  );

  immediate_encode #(.ERR_CNT_W(2)) u_sat (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
    .IMM(IMM), .IMM_SEL(IMM_SEL), .BASE(BASE), .OUT_VALID(s_out_valid),
    .OUT_READY(OUT_READY), .OUT(s_out), .OUT_ERR(s_out_err),
    .ERR_STICKY(s_sticky), .ERR_CNT(s_cnt), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [24:0] out;
    logic        err;
    logic [2:0]  sel;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cnt_m = 0;
  int          scnt_m = 0;
  logic        sticky_m = 1'b0;
  logic        hand_v = 1'b0;
  logic [24:0] hand_out;
  logic        hand_err;
  logic        last_in_fire;
  logic        stall_prev = 1'b0;
  logic [24:0] stall_out;
  logic        stall_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding: build the full instruction word the way the ISA manual draws it.
  function automatic logic [24:0] model_enc(input logic [31:0] imm, input logic [2:0] sel,
                                            input logic [24:0] base);
    logic [31:0] ins;
    ins = {base, 7'b0};
    case (sel)
      3'd0: ins[31:12] = imm[31:12];
      3'd1: ins[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
      3'd2: begin ins[31:25] = imm[11:5]; ins[11:7] = imm[4:0]; end
      3'd3: begin ins[31] = imm[12]; ins[30:25] = imm[10:5]; ins[11:8] = imm[4:1]; ins[7] = imm[11]; end
      3'd4, 3'd6: ins[31:20] = imm[11:0];
      3'd5: ins[24:20] = imm[4:0];
      default: ins = {base, 7'b0};
    endcase
    return ins[31:7];
  endfunction

  function automatic logic model_err(input logic [31:0] imm, input logic [2:0] sel);
    int si;
    si = $signed(imm);
    case (sel)
      3'd0: return imm[11:0] != 12'd0;
      3'd1: return imm[0] || si < -1048576 || si > 1048575;
      3'd3: return imm[0] || si < -4096 || si > 4095;
      3'd2, 3'd4: return si < -2048 || si > 2047;
      3'd6: return imm > 32'd4095;
      3'd5: return imm > 32'd31;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [24:0] o, input logic [2:0] sel);
    logic [31:0] i;
    i = {o, 7'b0};
    case (sel)
      3'd0: return {i[31:12], 12'b0};
      3'd1: return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'd2: return {{21{i[31]}}, i[30:25], i[11:7]};
      3'd3: return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'd4: return {{21{i[31]}}, i[30:20]};
      3'd6: return {20'b0, i[31:20]};
      3'd5: return {27'b0, i[24:20]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] gen_legal(input logic [2:0] sel);
    logic [31:0] r;
    r = $urandom;
    case (sel)
      3'd0: return r & 32'hFFFF_F000;
      3'd1: return {{11{r[20]}}, r[20:1], 1'b0};
      3'd3: return {{19{r[12]}}, r[12:1], 1'b0};
      3'd2, 3'd4: return {{20{r[11]}}, r[11:0]};
      3'd6: return {20'b0, r[11:0]};
      default: return {27'b0, r[4:0]};
    endcase
  endfunction

  // One clock: sample handshakes before the edge, update scoreboard/models, check after.
  task automatic step();
    exp_t e;
    logic out_fire;
    logic fire_err;
    #1;
    last_in_fire = IN_VALID && in_ready;
    out_fire     = out_valid && OUT_READY;
    fire_err     = 1'b0;
    if (stall_prev) begin
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_out", {7'b0, out_w}, {7'b0, stall_out});
      check("hold_err", {31'b0, out_err}, {31'b0, stall_err});
    end
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        fire_err = e.err;
        check("out", {7'b0, out_w}, {7'b0, e.out});
        check("out_err", {31'b0, out_err}, {31'b0, e.err});
        check("sat_out", {7'b0, s_out}, {7'b0, e.out});
        if (!e.err && e.sel != 3'b111) check("roundtrip", decode(out_w, e.sel), e.imm);
      end
    end
    if (last_in_fire) begin
      e.out = hand_v ? hand_out : model_enc(IMM, IMM_SEL, BASE);
      e.err = hand_v ? hand_err : model_err(IMM, IMM_SEL);
      e.sel = IMM_SEL;
      e.imm = IMM;
      sb.push_back(e);
    end
    if (CLR_ERR) begin
      cnt_m = 0; scnt_m = 0; sticky_m = 1'b0;
    end else if (out_fire && fire_err) begin
      sticky_m = 1'b1;
      cnt_m++;
      if (scnt_m < 3) scnt_m++;
    end
    stall_prev = out_valid && !OUT_READY;
    stall_out  = out_w;
    stall_err  = out_err;
    @(posedge CLK);
    #1;
    check("err_cnt", {16'b0, err_cnt}, cnt_m);
    check("sticky", {31'b0, err_sticky}, {31'b0, sticky_m});
    check("sat_cnt", {30'b0, s_cnt}, scnt_m);
  endtask

  task automatic push_req(input logic [31:0] imm, input logic [2:0] sel, input logic [24:0] base);
    IMM = imm; IMM_SEL = sel; BASE = base; IN_VALID = 1'b1;
    last_in_fire = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (last_in_fire) break;
    end
    check("accept_timeout", {31'b0, last_in_fire}, 32'd1);
  endtask

  task automatic drain();
    IN_VALID = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    cnt_m = 0; scnt_m = 0; sticky_m = 1'b0; stall_prev = 1'b0;
  endtask

  typedef struct { logic [31:0] imm; logic [2:0] sel; } vec_t;
  vec_t vecs[$];
  int   bp_i;
  int   snap;

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; CLR_ERR = 1'b0;
    IMM = 32'd0; IMM_SEL = 3'd0; BASE = 25'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", {7'b0, out_w}, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_sticky", {31'b0, err_sticky}, 32'd0);
    check("rst_cnt", {16'b0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    RESET = 1'b0;
    OUT_READY = 1'b1;

    // Hand-computed vectors from the plan.
    hand_v = 1'b1;
    hand_out = 25'h10000A5; hand_err = 1'b0; push_req(32'hFFFF_F800, 3'b100, 25'h00000A5);
    hand_out = 25'h10000A5; hand_err = 1'b1; push_req(32'h0000_0800, 3'b100, 25'h00000A5);
    hand_out = 25'h1000F0E; hand_err = 1'b0; push_req(32'hFFFF_F00E, 3'b011, 25'h00C0F00);
    hand_out = 25'h0000F02; hand_err = 1'b1; push_req(32'h0000_0003, 3'b011, 25'h00C0F00);
    hand_v = 1'b0;
    drain();
    check("cnt_after_directed", {16'b0, err_cnt}, 32'd2);

    // Format boundaries, legal and illegal.
    vecs = '{'{32'h1234_5000, 3'd0}, '{32'h1234_5001, 3'd0}, '{32'hFFF0_0000, 3'd1},
             '{32'h0010_0000, 3'd1}, '{32'h000F_FFFE, 3'd1}, '{32'h0000_0002, 3'd1},
             '{32'h0000_07FF, 3'd2}, '{32'hFFFF_F7FF, 3'd2}, '{32'h0000_0FFE, 3'd3},
             '{32'hFFFF_F000, 3'd3}, '{32'h0000_001F, 3'd5}, '{32'h0000_0020, 3'd5},
             '{32'h0000_0FFF, 3'd6}, '{32'h0000_1000, 3'd6}, '{32'h0000_0000, 3'd7}};
    foreach (vecs[v]) push_req(vecs[v].imm, vecs[v].sel, 25'($urandom));
    drain();

    // Random legal round trip at full throughput.
    snap = cnt_m;
    for (int n = 0; n < 1000; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 6));
      push_req(gen_legal(sel), sel, 25'($urandom));
    end
    drain();
    check("rt_no_errors", {16'b0, err_cnt}, snap);

    // Backpressure: 8 back-to-back requests, output stalled for 5 cycles.
    bp_i = 0;
    IMM = 32'd0 - 32'd100; IMM_SEL = 3'b100; BASE = 25'd0; IN_VALID = 1'b1;
    for (int c = 0; c < 60; c++) begin
      OUT_READY = (c >= 5);
      step();
      if (last_in_fire) begin
        bp_i++;
        if (bp_i < 8) begin
          IMM = 32'(bp_i * 37) - 32'd100; BASE = 25'(bp_i);
        end else begin
          IN_VALID = 1'b0;
        end
      end
      if (c == 4) begin
        check("bp_accepts", bp_i, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (bp_i == 8) break;
    end
    check("bp_all_sent", bp_i, 32'd8);
    drain();

    // Saturation of the 2-bit counter, then clear coincident with an errored handshake.
    CLR_ERR = 1'b1; IN_VALID = 1'b0; step(); CLR_ERR = 1'b0;
    for (int n = 0; n < 5; n++) push_req(32'(n), 3'b111, 25'($urandom));
    drain();
    check("sat_at_3", {30'b0, s_cnt}, 32'd3);
    check("cnt_5", {16'b0, err_cnt}, 32'd5);
    OUT_READY = 1'b0;
    push_req(32'h5, 3'b111, 25'h1);
    IN_VALID = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      step();
    end
    OUT_READY = 1'b1; CLR_ERR = 1'b1;
    step();
    CLR_ERR = 1'b0;
    check("clr_wins_cnt", {30'b0, s_cnt}, 32'd0);
    check("clr_wins_sticky", {31'b0, s_sticky}, 32'd0);
    check("clr_wins_cnt16", {16'b0, err_cnt}, 32'd0);
    drain();

    // Asynchronous reset with two items in flight.
    push_req(32'h0, 3'b111, 25'h3);
    drain();
    push_req(32'h7, 3'b110, 25'h11);
    push_req(32'h9, 3'b110, 25'h22);
    IN_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out", {7'b0, out_w}, 32'd0);
    check("arst_sticky", {31'b0, err_sticky}, 32'd0);
    check("arst_cnt", {16'b0, err_cnt}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b0;
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    push_req(32'h0000_0ABC, 3'b110, 25'h155);
    IN_VALID = 1'b0;
    check("lat_edge1", {31'b0, out_valid}, 32'd0);
    step();
    check("lat_edge2", {31'b0, out_valid}, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
